// File: rtl/nibble_frame_demux_pkg.sv
// rtl/nibble_frame_demux_pkg.sv - shared state enum, slot encoding and width default
package nibble_frame_demux_pkg;

  localparam int NIBBLE_W_DEF = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Same encoding as the calculator's 4-to-1 nibble selector
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/nibble_frame_demux.sv
// rtl/nibble_frame_demux.sv - 1-to-4 nibble distributor assembling frames of four nibbles
module nibble_frame_demux
  import nibble_frame_demux_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NIBBLE_W-1:0] in_nibble,
  input  logic                in_valid,
  input  logic                in_first,
  output logic                in_ready,
  output logic [NIBBLE_W-1:0] out_A,
  output logic [NIBBLE_W-1:0] out_B,
  output logic [NIBBLE_W-1:0] out_C,
  output logic [NIBBLE_W-1:0] out_D,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          slot_idx,
  output logic                frame_error
);

  state_e                     state_q, state_d;
  logic [1:0]                 slot_q, slot_d;
  logic [3:0][NIBBLE_W-1:0]   coll_q, coll_d;
  logic [3:0][NIBBLE_W-1:0]   out_q, out_d;
  logic                       ov_q, ov_d;
  logic                       ferr_q, ferr_d;
  logic                       in_acc, out_acc;

  assign in_ready = (state_q == COLLECT);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = ov_q && out_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    coll_d  = coll_q;
    out_d   = out_q;
    ov_d    = ov_q;
    ferr_d  = 1'b0;

    if (out_acc) ov_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (in_acc) begin
          if (in_first && (slot_q != SLOT_A)) begin
            // Resync: partial frame is dropped, new nibble restarts at slot A
            coll_d[SLOT_A] = in_nibble;
            slot_d         = SLOT_B;
            ferr_d         = 1'b1;
          end else begin
            coll_d[slot_q] = in_nibble;
            slot_d         = slot_q + 2'd1;
            if (slot_q == SLOT_D) begin
              if (!ov_q || out_acc) begin
                out_d = coll_d;
                ov_d  = 1'b1;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
      end
      HOLD: begin
        if (out_acc) begin
          out_d   = coll_q;
          ov_d    = 1'b1;
          slot_d  = SLOT_A;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      slot_q  <= SLOT_A;
      coll_q  <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      coll_q  <= coll_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      ferr_q  <= ferr_d;
    end
  end

  assign out_A       = out_q[SLOT_A];
  assign out_B       = out_q[SLOT_B];
  assign out_C       = out_q[SLOT_C];
  assign out_D       = out_q[SLOT_D];
  assign out_valid   = ov_q;
  assign slot_idx    = slot_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_nibble_frame_demux.sv
// tb/tb_nibble_frame_demux.sv - randomized and directed checks against a queue-based frame model
module tb_nibble_frame_demux;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_nibble;
  logic       in_valid;
  logic       in_first;
  logic       in_ready;
  logic [3:0] out_A, out_B, out_C, out_D;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] slot_idx;
  logic       frame_error;

  int total = 0;
  int bad   = 0;

  // Model: nibbles collected so far, visible output frame, and a frame parked while output is busy
  logic [3:0]  part[$];
  logic [15:0] m_out;
  bit          m_ov;
  bit          m_held;
  logic [15:0] m_hold;
  bit          m_ferr;

  nibble_frame_demux #(.NIBBLE_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_nibble(in_nibble), .in_valid(in_valid), .in_first(in_first), .in_ready(in_ready),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_D(out_D),
    .out_valid(out_valid), .out_ready(out_ready),
    .slot_idx(slot_idx), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("frame", {out_D, out_C, out_B, out_A}, m_out);
    check_eq("out_valid", out_valid, m_ov);
    check_eq("in_ready", in_ready, !m_held);
    check_eq("frame_error", frame_error, m_ferr);
    if (!m_held) check_eq("slot_idx", slot_idx, part.size());
  endtask

  task automatic model_clear();
    part.delete();
    m_out  = '0;
    m_ov   = 0;
    m_held = 0;
    m_hold = '0;
    m_ferr = 0;
  endtask

  // Called at a negedge; leaves the bench at a negedge with reset released
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic cyc(input bit v, input logic [3:0] n, input bit f, input bit r);
    bit ia, oa;
    logic [15:0] fr;
    in_valid  = v;
    in_nibble = n;
    in_first  = f;
    out_ready = r;
    ia = v && !m_held;
    oa = m_ov && r;
    @(posedge clk);
    m_ferr = 0;
    if (oa) begin
      if (m_held) begin
        m_out  = m_hold;
        m_held = 0;
      end else begin
        m_ov = 0;
      end
    end
    if (ia) begin
      if (f && part.size() != 0) begin
        part.delete();
        part.push_back(n);
        m_ferr = 1;
      end else begin
        part.push_back(n);
        if (part.size() == 4) begin
          fr = {part[3], part[2], part[1], part[0]};
          part.delete();
          if (!m_ov) begin
            m_out = fr;
            m_ov  = 1;
          end else begin
            m_hold = fr;
            m_held = 1;
          end
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset_n = 1'b0; in_nibble = '0; in_valid = 0; in_first = 0; out_ready = 0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single frame 1,2,3,4 with consumer ready
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 1);
    check_eq("t1_frame", {out_D, out_C, out_B, out_A}, 32'h4321);
    check_eq("t1_valid", out_valid, 1);
    cyc(0, 0, 0, 1);
    check_eq("t1_valid_drop", out_valid, 0);

    // Backpressure: second frame parks, then drains
    for (int i = 5; i <= 12; i++) cyc(1, 4'(i), 0, 0);
    check_eq("t2_held_frame", {out_D, out_C, out_B, out_A}, 32'h8765);
    check_eq("t2_in_ready", in_ready, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    check_eq("t6_stable", {out_D, out_C, out_B, out_A}, 32'h8765);
    cyc(0, 0, 0, 1);
    check_eq("t2_drain_frame", {out_D, out_C, out_B, out_A}, 32'hCBA9);
    check_eq("t2_drain_ready", in_ready, 1);
    cyc(0, 0, 0, 1);

    // Resync on nibble 7
    cyc(1, 4'h1, 1, 1);
    cyc(1, 4'h2, 0, 1);
    cyc(1, 4'h7, 1, 1);
    check_eq("t3_ferr", frame_error, 1);
    cyc(1, 4'h8, 0, 1);
    check_eq("t3_ferr_once", frame_error, 0);
    cyc(1, 4'h9, 0, 1);
    cyc(1, 4'hA, 0, 1);
    check_eq("t3_frame", {out_D, out_C, out_B, out_A}, 32'hA987);

    // Continuous stream, no stalls
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(1, 4'(i), 0, 1);
      check_eq("t4_no_stall", in_ready, 1);
    end
    check_eq("t4_last_frame", {out_D, out_C, out_B, out_A}, 32'hBA98);

    // Reset mid-frame
    cyc(1, 4'h3, 0, 1);
    cyc(1, 4'h3, 0, 1);
    do_reset();
    for (int i = 4; i <= 7; i++) cyc(1, 4'(i), 0, 1);
    check_eq("t5_frame", {out_D, out_C, out_B, out_A}, 32'h7654);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 99) < 12,
          $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
